// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame sequencer: start qualification, shifter handoff, parity/stop sampling, status word push.
// Optional macro UART_RX_FRAME_CTRL_SYNC_EN adds a 2-flop synchronizer on serial_in.
module uart_rx_frame_ctrl #(
   parameter int SHIFT_TIMEOUT = 192
) (
   input  logic        bclk_in,
   input  logic        rstn_in,
   input  logic        enable_in,
   input  logic        osm_sel_in,
   input  logic [1:0]  wls_in,
   input  logic        pen_in,
   input  logic        eps_in,
   input  logic        sp_in,
   input  logic        serial_in,
   output logic        shift_start_out,
   input  logic        shift_done_in,
   input  logic [7:0]  shift_data_in,
   input  logic        fifo_full_in,
   output logic        fifo_wr_out,
   output logic [10:0] fifo_wdata_out,
   output logic        overrun_out,
   output logic        timeout_err_out,
   output logic        busy_out
);

   typedef enum logic [2:0] {
      IDLE, START, WAIT_SHIFT, PARITY, STOP, PUSH, BRK_WAIT
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(SHIFT_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q;
   logic       osm_q, pen_q, eps_q, sp_q;
   logic [1:0] wls_q;
   logic [7:0] data_q;
   logic       p_q, stop_q;
   logic       rx;
   logic       at_mid, at_last, start_entry;
   logic       pe, fe, bi, exp_p;
   logic [7:0] data_mask;

`ifdef UART_RX_FRAME_CTRL_SYNC_EN
   logic [1:0] sync_q;
   always_ff @(posedge bclk_in or negedge rstn_in) begin
      if (!rstn_in) sync_q <= 2'b11;
      else          sync_q <= {sync_q[0], serial_in};
   end
   assign rx = sync_q[1];
`else
   assign rx = serial_in;
`endif

   assign at_mid      = (cnt_q == (osm_q ? 8'd6  : 8'd8));
   assign at_last     = (cnt_q == (osm_q ? 8'd12 : 8'd15));
   assign start_entry = (state_q == IDLE) && (state_d == START);
   assign data_mask   = 8'hFF >> (2'd3 - wls_in_q());

   function automatic logic [1:0] wls_in_q();
      return wls_q;
   endfunction

   // Stick parity forces a fixed bit; otherwise the bit completes the selected parity.
   assign exp_p = sp_q ? ~eps_q : (^data_q) ^ ~eps_q;
   assign pe    = pen_q & (p_q != exp_p);
   assign fe    = ~stop_q;
   assign bi    = (data_q == 8'd0) & (~pen_q | ~p_q) & ~stop_q;
   assign busy_out = (state_q != IDLE);

   always_ff @(posedge bclk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         osm_q   <= 1'b0;
         wls_q   <= '0;
         pen_q   <= 1'b0;
         eps_q   <= 1'b0;
         sp_q    <= 1'b0;
         data_q  <= '0;
         p_q     <= 1'b0;
         stop_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         if (state_d != state_q || state_q == IDLE || state_q == BRK_WAIT)
            cnt_q <= '0;
         else if (state_q != WAIT_SHIFT && at_last)
            cnt_q <= '0;
         else
            cnt_q <= cnt_q + 8'd1;
         if (start_entry) begin
            osm_q <= osm_sel_in;
            wls_q <= wls_in;
            pen_q <= pen_in;
            eps_q <= eps_in;
            sp_q  <= sp_in;
            p_q   <= 1'b0;
         end
         if (state_q == WAIT_SHIFT && shift_done_in)
            data_q <= shift_data_in & data_mask;
         if (state_q == PARITY && at_mid)
            p_q <= rx;
         if (state_q == STOP && at_mid)
            stop_q <= rx;
      end
   end

   always_comb begin
      state_d         = state_q;
      shift_start_out = 1'b0;
      fifo_wr_out     = 1'b0;
      fifo_wdata_out  = '0;
      overrun_out     = 1'b0;
      timeout_err_out = 1'b0;
      case (state_q)
         IDLE:
            if (!rx) state_d = START;
         START:
            if (at_mid && rx) state_d = IDLE;
            else if (at_last) begin
               shift_start_out = 1'b1;
               state_d         = WAIT_SHIFT;
            end
         WAIT_SHIFT:
            // done has priority over a same-cycle timeout
            if (shift_done_in) state_d = pen_q ? PARITY : STOP;
            else if (cnt_q == TMO_LAST) begin
               timeout_err_out = 1'b1;
               state_d         = IDLE;
            end
         PARITY:
            if (at_last) state_d = STOP;
         STOP:
            if (at_mid) state_d = PUSH;
         PUSH: begin
            if (fifo_full_in) overrun_out = 1'b1;
            else begin
               fifo_wr_out    = 1'b1;
               fifo_wdata_out = {bi, fe, pe, data_q};
            end
            state_d = bi ? BRK_WAIT : IDLE;
         end
         BRK_WAIT:
            if (rx) state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
      if (!enable_in) begin
         state_d         = IDLE;
         shift_start_out = 1'b0;
         fifo_wr_out     = 1'b0;
         fifo_wdata_out  = '0;
         overrun_out     = 1'b0;
         timeout_err_out = 1'b0;
      end
   end

endmodule
